// File: rtl/ov7670_source.sv
// OV7670-style camera source: emits VSYNC/HREF/D byte timing from pixel memory or colour bars.
// Counters run two PCLK ahead of the pins; stage 1 issues memory reads, stage 2 drives D.
module ov7670_source #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int V_ACTIVE  = 480,
    parameter int VFP_LINES = 10,
    parameter int BPP       = 2
) (
    input  logic        pclk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        pattern_i,
    input  logic [15:0] pix_data_i,
    output logic [18:0] pix_addr_o,
    output logic        pix_rd_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  d_o,
    output logic        frame_done_o
);
    localparam int H_TOTAL = (H_ACTIVE + H_BLANK) * BPP;
    localparam int V_TOTAL = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_B = HW'(H_ACTIVE * BPP);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_END  = VW'(VS_LINES);
    localparam logic [VW-1:0] VA_BEG  = VW'(VS_LINES + VBP_LINES);
    localparam logic [VW-1:0] VA_END  = VW'(VS_LINES + VBP_LINES + V_ACTIVE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic            pat_q, pat_d;

    logic            run, frame_end, vs0, href0, rd0;
    logic [HW-1:0]   pix_idx;
    logic [2:0]      bar;

    logic            s1_vs_q, s1_href_q, s1_odd_q, s1_last_q, s1_pat_q;
    logic [15:0]     s1_col_q;
    logic [18:0]     addr_cnt_q, pix_addr_q;
    logic            pix_rd_q;
    logic            vsync_q, href_q, s2_last_q, frame_done_q;
    logic [7:0]      d_q, lo_q;
    logic [15:0]     word;

    function automatic logic [15:0] bar_colour(input logic [2:0] b);
        case (b)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    assign run       = (state_q == RUN);
    assign frame_end = run && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        pat_d   = pat_q;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (enable_i) begin
                    state_d = RUN;
                    pat_d   = pattern_i;
                end
            end
            RUN: begin
                hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
                if (hcnt_q == H_LAST)
                    vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
                // Pattern is only re-sampled at a frame boundary; a cleared enable ends here.
                if (frame_end) begin
                    if (enable_i) pat_d = pattern_i;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            pat_q   <= pat_d;
        end
    end

    assign vs0     = run && (vcnt_q < VS_END);
    assign href0   = run && (vcnt_q >= VA_BEG) && (vcnt_q < VA_END) && (hcnt_q < H_ACT_B);
    assign rd0     = href0 && !hcnt_q[0] && !pat_q;
    assign pix_idx = hcnt_q / HW'(BPP);
    assign bar     = 3'(pix_idx / HW'(BAR_W));

    // Stage 1: timing flags and the memory read for the upcoming even byte.
    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            s1_vs_q    <= 1'b0;
            s1_href_q  <= 1'b0;
            s1_odd_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_pat_q   <= 1'b0;
            s1_col_q   <= '0;
            addr_cnt_q <= '0;
            pix_addr_q <= '0;
            pix_rd_q   <= 1'b0;
        end else begin
            s1_vs_q   <= vs0;
            s1_href_q <= href0;
            s1_odd_q  <= hcnt_q[0];
            s1_last_q <= frame_end;
            s1_pat_q  <= pat_q;
            s1_col_q  <= bar_colour(bar);
            pix_rd_q  <= rd0;
            if (rd0) begin
                pix_addr_q <= addr_cnt_q;
                addr_cnt_q <= addr_cnt_q + 1'b1;
            end
            if (!run || frame_end) addr_cnt_q <= '0;
        end
    end

    assign word = s1_pat_q ? s1_col_q : pix_data_i;

    // Stage 2: pins. The low byte is held from the word captured on the even byte.
    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            s2_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            d_q          <= '0;
            lo_q         <= '0;
        end else begin
            vsync_q      <= s1_vs_q;
            href_q       <= s1_href_q;
            s2_last_q    <= s1_last_q;
            frame_done_q <= s2_last_q;
            if (!s1_href_q) begin
                d_q <= '0;
            end else if (!s1_odd_q) begin
                d_q  <= word[15:8];
                lo_q <= word[7:0];
            end else begin
                d_q <= lo_q;
            end
        end
    end

    assign pix_addr_o   = pix_addr_q;
    assign pix_rd_o     = pix_rd_q;
    assign vsync_o      = vsync_q;
    assign href_o       = href_q;
    assign d_o          = d_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_ov7670_source.sv
// Bench for ov7670_source on a shrunken frame: 16x4 active, 40 bytes/line, 10 lines/frame.
// Expected bytes are queued per frame and popped by a negedge monitor whenever HREF is high.
module tb_ov7670_source;
    localparam int HA = 16, HB = 4, VS = 2, VBP = 2, VA = 4, VFP = 2, BPP = 2;
    localparam int LINE  = (HA + HB) * BPP;
    localparam int FRAME = LINE * (VS + VBP + VA + VFP);

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, pat = 1'b0;
    logic [15:0] pix_data;
    logic [18:0] pix_addr;
    logic        pix_rd, vsync, href, fd;
    logic [7:0]  d;

    int checks = 0, failures = 0;
    int cyc = 0, hr_cnt = 0, pr_cnt = 0, fd_cnt = 0;
    logic href_prev = 1'b0;
    logic [7:0]  exp_q[$];
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;

    // Memory returns address[15:0] in the cycle after PixAddr is presented.
    assign pix_data = pix_addr[15:0];

    ov7670_source #(.H_ACTIVE(HA), .H_BLANK(HB), .VS_LINES(VS), .VBP_LINES(VBP),
                    .V_ACTIVE(VA), .VFP_LINES(VFP), .BPP(BPP)) dut (
        .pclk_i(clk), .reset_i(rst), .enable_i(en), .pattern_i(pat),
        .pix_data_i(pix_data), .pix_addr_o(pix_addr), .pix_rd_o(pix_rd),
        .vsync_o(vsync), .href_o(href), .d_o(d), .frame_done_o(fd));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (href) begin
            check("byte_avail", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("d_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end else begin
            check("d_zero_outside_href", {24'd0, d}, 0);
        end
        if (href && !href_prev) hr_cnt <= hr_cnt + 1;
        if (pix_rd) pr_cnt <= pr_cnt + 1;
        if (fd) fd_cnt <= fd_cnt + 1;
        href_prev <= href;
    end

    task automatic push_mem_frame();
        logic [15:0] a;
        for (int l = 0; l < VA; l++)
            for (int p = 0; p < HA; p++) begin
                a = 16'(l * HA + p);
                exp_q.push_back(a[15:8]);
                exp_q.push_back(a[7:0]);
            end
    endtask

    task automatic push_bar_frame();
        logic [15:0] c;
        for (int l = 0; l < VA; l++)
            for (int p = 0; p < HA; p++) begin
                c = bars[p / (HA / 8)];
                exp_q.push_back(c[15:8]);
                exp_q.push_back(c[7:0]);
            end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return vsync;
            1:       return href;
            2:       return fd;
            default: return pix_rd;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic lvl, input int maxc,
                            input string tag, output int n);
        n = 0;
        while (sig(sel) !== lvl && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_reached"}, {31'd0, sig(sel)}, {31'd0, lvl});
    endtask

    initial begin
        int n, t0, t1, t2, h0, p0, h1, p1, f1, bad;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vsync", vsync, 0);
        check("rst_href", href, 0);
        check("rst_d", d, 0);
        check("rst_pixrd", pix_rd, 0);
        check("rst_done", fd, 0);
        check("rst_addr", pix_addr, 0);

        // Frame 1: memory source, continuous enable.
        push_mem_frame();
        h0 = hr_cnt; p0 = pr_cnt;
        rst = 1'b0; en = 1'b1;
        wait_for(0, 1'b1, 10, "vsync_rise", n);
        check("vsync_latency", n, 3);
        t0 = cyc;
        wait_for(0, 1'b0, 2 * FRAME, "vsync_fall", n);
        check("vsync_width", n, VS * LINE);
        wait_for(1, 1'b1, 2 * FRAME, "href_rise", n);
        check("href_first_rise", 32'(cyc - t0), (VS + VBP) * LINE);
        wait_for(1, 1'b0, 2 * FRAME, "href_fall", n);
        check("href_high", n, HA * BPP);
        wait_for(1, 1'b1, 2 * FRAME, "href_rise2", n);
        check("href_low", n, HB * BPP);
        pat = 1'b1;
        wait_for(2, 1'b1, 2 * FRAME, "done1", n);
        check("frame1_len", 32'(cyc - t0), FRAME);
        check("vsync_with_done", vsync, 1);
        check("frame1_href_pulses", 32'(hr_cnt - h0), VA);
        check("frame1_pixrd", 32'(pr_cnt - p0), VA * HA);
        check("frame1_bytes_left", 32'(exp_q.size()), 0);
        check("frame1_last_addr", pix_addr, VA * HA - 1);

        // Frame 2: colour bars; pattern/enable changes mid-frame.
        f1 = fd_cnt; t1 = cyc;
        push_bar_frame();
        h1 = hr_cnt; p1 = pr_cnt;
        @(posedge clk); #1;
        check("done_one_cycle", fd, 0);
        wait_for(1, 1'b1, 2 * FRAME, "f2_href_rise", n);
        wait_for(1, 1'b0, 2 * FRAME, "f2_href_fall", n);
        wait_for(1, 1'b1, 2 * FRAME, "f2_href_rise2", n);
        en = 1'b0; pat = 1'b0;
        wait_for(2, 1'b1, 2 * FRAME, "done2", n);
        check("frame2_len", 32'(cyc - t1), FRAME);
        check("frame2_href_pulses", 32'(hr_cnt - h1), VA);
        check("frame2_pixrd", 32'(pr_cnt - p1), 0);
        check("frame2_bytes_left", 32'(exp_q.size()), 0);
        check("frame2_done_pulses", 32'(fd_cnt - f1), 1);
        check("addr_hold", pix_addr, VA * HA - 1);
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (vsync || href || fd || pix_rd || d != 8'd0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Frame 3: start from idle, then reset mid-line during HREF.
        en = 1'b1;
        push_mem_frame();
        wait_for(0, 1'b1, 10, "idle_vsync_rise", n);
        check("idle_vsync_latency", n, 3);
        wait_for(1, 1'b1, 2 * FRAME, "f3_href_rise", n);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_href", href, 0);
        check("midrst_d", d, 0);
        check("midrst_vsync", vsync, 0);
        check("midrst_pixrd", pix_rd, 0);
        exp_q.delete();
        push_mem_frame();
        h0 = hr_cnt;
        rst = 1'b0;
        wait_for(0, 1'b1, 10, "rst_vsync_rise", n);
        check("restart_latency", n, 3);
        t2 = cyc;
        en = 1'b0;
        wait_for(2, 1'b1, 2 * FRAME, "done3", n);
        check("frame3_len", 32'(cyc - t2), FRAME);
        check("frame3_href_pulses", 32'(hr_cnt - h0), VA);
        check("frame3_bytes_left", 32'(exp_q.size()), 0);
        check("frame3_last_addr", pix_addr, VA * HA - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ov7670_source.md
OV7670_SOURCE -- requirements
Module: ov7670_source

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set active pixels per line.
REQ-002 Parameter H_BLANK, default 144, SHALL set blanking pixels per line.
REQ-003 Parameters VS_LINES 3, VBP_LINES 17, V_ACTIVE 480, VFP_LINES 10 SHALL set the vertical sync, back porch, active and front porch line counts.
REQ-004 Parameter BPP, default 2, SHALL set bytes per pixel (RGB565, high byte first).
REQ-005 PCLK  in  1  SHALL be the single clock; all outputs SHALL change on its rising edge.
REQ-006 Reset  in  1  SHALL be the synchronous, active-high reset, sampled on PCLK.
REQ-007 Enable  in  1  SHALL request continuous frame generation.
REQ-008 Pattern  in  1  SHALL select the data source: 0 = pixel memory, 1 = colour bars; sampled only at frame start.
REQ-009 PixData  in  16  SHALL be memory read data, valid one PCLK after PixAddr/PixRd.
REQ-010 PixAddr  out  19  SHALL be the pixel memory address, row-major (line*H_ACTIVE + pixel).
REQ-011 PixRd  out  1  SHALL pulse one cycle per pixel read.
REQ-012 VSYNC  out  1  SHALL be the camera-side vertical sync, active high.
REQ-013 HREF  out  1  SHALL be high only while valid bytes are on D.
REQ-014 D  out  8  SHALL be the pixel byte bus.
REQ-015 FrameDone  out  1  SHALL pulse one cycle at the end of each frame.

Function
REQ-016 States SHALL be IDLE and RUN; IDLE->RUN when Enable=1 in IDLE; RUN->IDLE at frame end when Enable=0; RUN->RUN (next frame) at frame end when Enable=1.
REQ-017 In RUN, byte counter hcnt SHALL count 0..(H_ACTIVE+H_BLANK)*BPP-1 (0..1567) and wrap, incrementing line counter vcnt 0..509, which wraps at frame end.
REQ-018 Internal VSYNC SHALL be 1 for vcnt<VS_LINES; internal HREF SHALL be 1 for VS_LINES+VBP_LINES <= vcnt < VS_LINES+VBP_LINES+V_ACTIVE (20..499) and hcnt<H_ACTIVE*BPP (0..1279).
REQ-019 Counters SHALL lead the pins by exactly 2 PCLK: internal VSYNC/HREF delayed 2 stages; PixAddr/PixRd registered at stage 1 on each even hcnt inside HREF; D driven at stage 2.
REQ-020 D SHALL carry PixData[15:8] on even-hcnt bytes and PixData[7:0] on odd-hcnt bytes (low byte held from the captured word); D SHALL be 0 whenever HREF=0.
REQ-021 Colour bars SHALL be 8 bars of H_ACTIVE/8 pixels: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (left to right), identical on all lines; PixRd SHALL stay 0 in this mode.
REQ-022 Pattern change mid-frame SHALL take effect only at the next frame start.
REQ-023 Enable deassertion mid-frame SHALL complete the current frame in full before IDLE.
REQ-024 FrameDone SHALL assert the cycle after the last byte of vcnt 509 reaches the pins (aligned with the 2-stage pipeline).
REQ-025 In IDLE, VSYNC, HREF, D, PixRd, FrameDone SHALL be 0 and counters held at 0.
REQ-026 PixAddr SHALL reach 307199 on the final active pixel and restart at 0 each frame; it SHALL hold its last value outside active reads.

Reset
REQ-027 Reset=1 SHALL force state IDLE, hcnt=vcnt=0, pipeline stages cleared, and all outputs 0 on the next PCLK edge, including mid-frame.
REQ-028 After Reset release with Enable=1, the first VSYNC=1 SHALL appear on the pins 3 PCLK after the first edge with Reset=0 (1 to enter RUN + 2 pipeline).

Verification
REQ-029 Reset release, Enable=1, Pattern=0 -> VSYNC high for 3*1568 PCLK, first HREF rise 20*1568 PCLK after VSYNC rise, HREF high 1280 PCLK, low 288 PCLK.
REQ-030 Memory model PixData = address[15:0], 1-cycle latency -> D bytes of line 0 are 00,00,00,01,00,02...; line 1 starts 02,80 (address 640).
REQ-031 Full frame count -> exactly 480 HREF pulses, 307200 PixRd pulses, one FrameDone, frame length 510*1568 = 799680 PCLK.
REQ-032 Pattern=1 -> bytes FF,FF for pixels 0..79, FF,E0 for 80..159, ... 00,00 for 560..639; PixRd never high.
REQ-033 Enable dropped at line 100 -> frame completes through line 509, FrameDone pulses, then outputs remain 0.
REQ-034 Reset asserted mid-line during HREF=1 -> next cycle HREF=0, D=0, VSYNC=0; with Enable=1 after release, frame restarts at VSYNC per REQ-028.
